// File: rtl/ahb_mtx_input_stage_hold.sv
// AHB matrix input stage: captures each master address phase and holds it, stalling the
// master, until the output arbiters accept it; passes data-phase ready/response back.
module ahb_mtx_input_stage_hold #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  input  logic              addr_accept,
  input  logic              readyout_dec,
  input  logic              resp_dec,
  output logic              req_in,
  output logic              held_tran,
  output logic              sel_in,
  output logic [ADDR_W-1:0] addr_in,
  output logic [1:0]        trans_in,
  output logic              write_in,
  output logic [2:0]        size_in,
  output logic [2:0]        burst_in,
  output logic [3:0]        prot_in,
  output logic              master_lock_in,
  output logic              HREADYOUTS,
  output logic              HRESPS
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          trans_q, trans_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;
  logic [2:0]          burst_q, burst_d;
  logic [3:0]          prot_q, prot_d;
  logic                lock_q, lock_d;
  logic                trans_req;

  // Only NONSEQ/SEQ with the bus ready start a new transfer.
  assign trans_req = HSELS & HTRANSS[1] & HREADYS;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trans_req) state_d = addr_accept ? ST_DATA : ST_HOLD;
      end
      ST_HOLD: begin
        if (addr_accept) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (readyout_dec) begin
          if (trans_req) state_d = addr_accept ? ST_DATA : ST_HOLD;
          else           state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding registers track the bus whenever HREADY is high, so the entry cycle into
  // HOLD captures the new address phase rather than a stale one.
  always_comb begin
    sel_d   = sel_q;
    addr_d  = addr_q;
    trans_d = trans_q;
    write_d = write_q;
    size_d  = size_q;
    burst_d = burst_q;
    prot_d  = prot_q;
    lock_d  = lock_q;
    if (HREADYS) begin
      sel_d   = HSELS;
      addr_d  = HADDRS;
      trans_d = HTRANSS;
      write_d = HWRITES;
      size_d  = HSIZES;
      burst_d = HBURSTS;
      prot_d  = HPROTS;
      lock_d  = HMASTLOCKS;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      trans_q <= 2'b00;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      burst_q <= 3'b000;
      prot_q  <= 4'b0000;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      trans_q <= trans_d;
      write_q <= write_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      prot_q  <= prot_d;
      lock_q  <= lock_d;
    end
  end

  assign held_tran = (state_q == ST_HOLD);
  assign req_in    = held_tran | trans_req;

  // Combinational mux keeps first-cycle acceptance at zero added latency.
  assign sel_in         = held_tran ? sel_q   : HSELS;
  assign addr_in        = held_tran ? addr_q  : HADDRS;
  assign trans_in       = held_tran ? trans_q : HTRANSS;
  assign write_in       = held_tran ? write_q : HWRITES;
  assign size_in        = held_tran ? size_q  : HSIZES;
  assign burst_in       = held_tran ? burst_q : HBURSTS;
  assign prot_in        = held_tran ? prot_q  : HPROTS;
  assign master_lock_in = held_tran ? lock_q  : HMASTLOCKS;

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    case (state_q)
      ST_HOLD: HREADYOUTS = 1'b0;
      ST_DATA: begin
        HREADYOUTS = readyout_dec;
        HRESPS     = resp_dec;
      end
      default: begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
      end
    endcase
  end

endmodule
